uart_cmd_tx: RTL
================

UART_CMD_TX -- requirements
Module: uart_cmd_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, SHALL set the clk cycles per UART bit (50 MHz / 115200); legal range 2..65535.
REQ-002 Parameter NUM_BYTES, default 12, SHALL set the bytes per command frame (6 words).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 uart_start  in  1  level request; sampled only in IDLE.
REQ-006 cmd_buf  in  NUM_BYTES x 8  command bytes, packed [NUM_BYTES-1:0][7:0]; byte 0 is sent first.
REQ-007 tx  out  1  UART serial line, 8N1, idle high.
REQ-008 busy  out  1  high while a frame is in flight.
REQ-009 done  out  1  one-cycle pulse when the final stop bit completes.

Function
REQ-010 States SHALL be IDLE, START, DATA, STOP, and transitions SHALL occur only on bit-counter expiry or start acceptance.
REQ-011 In IDLE with uart_start=1, the block SHALL latch all of cmd_buf into an internal shadow buffer, clear the byte index, and enter START on the next cycle.
REQ-012 cmd_buf changes after acceptance SHALL NOT affect the frame in flight.
REQ-013 tx SHALL be registered: 0 in START, the data bit in DATA, 1 in STOP and IDLE.
REQ-014 Each of START, each DATA bit, and STOP SHALL last exactly CLKS_PER_BIT cycles, counted by a bit-timer that runs from 0 to CLKS_PER_BIT-1 and then wraps.
REQ-015 DATA SHALL send 8 bits LSB first using a 3-bit bit index; the index wraps 7->0 as DATA->STOP.
REQ-016 At STOP expiry, if byte index < NUM_BYTES-1, the block SHALL increment the index and return to START with no idle gap between bytes.
REQ-017 At STOP expiry of byte NUM_BYTES-1, the block SHALL enter IDLE and assert done for exactly that first IDLE cycle.
REQ-018 Frame length SHALL be NUM_BYTES*10*CLKS_PER_BIT cycles from the first tx low to the last STOP cycle inclusive.
REQ-019 busy SHALL be 1 in START/DATA/STOP and 0 in IDLE, including the done cycle.
REQ-020 If uart_start is held high, the block SHALL begin a new frame each time it is in IDLE, with exactly one IDLE cycle (tx=1) between frames; the new frame SHALL re-latch cmd_buf.
REQ-021 uart_start outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-022 Byte-index and bit-index registers SHALL be wide enough for NUM_BYTES and 8 respectively, with no overflow.

Reset
REQ-023 While rst_n=0, the block SHALL hold state=IDLE, tx=1, busy=0, done=0, all counters 0, and the shadow buffer 0.
REQ-024 Assertion of rst_n mid-frame SHALL immediately (asynchronously) force tx=1 and busy=0, and SHALL abort the frame with no done pulse.
REQ-025 After rst_n deasserts, the first frame SHALL start no earlier than the first rising clk edge with uart_start=1.

Verification (CLKS_PER_BIT=4, NUM_BYTES=12)
REQ-026 Reset release, uart_start=0 for 100 cycles -> tx=1, busy=0, done never asserted.
REQ-027 cmd_buf = {14,00,00,01,98,00x7} hex, single start -> decoded bytes 0x14,0x00,0x00,0x01,0x98, then seven 0x00; byte0 data bits 0,0,1,0,1,0,0,0; done exactly 480 cycles after first tx low.
REQ-028 uart_start held high continuously -> back-to-back identical frames, one tx=1 IDLE cycle between them, one done pulse per frame.
REQ-029 After acceptance, cmd_buf changed to all 0xFF mid-frame -> current frame still decodes the original bytes; next frame sends 0xFF.
REQ-030 rst_n pulsed low during byte 3 DATA -> tx=1 and busy=0 within the reset cycle, no done; a fresh start then sends a complete 12-byte frame.
REQ-031 Single-cycle uart_start pulse during busy -> ignored; exactly one frame and one done.

Source files
------------

// File: rtl/uart_cmd_tx.sv
// Serialises a latched NUM_BYTES command buffer as back-to-back 8N1 UART bytes, byte 0 first.
// A frame starts from IDLE on uart_start and ends with a one-cycle done pulse.
module uart_cmd_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int NUM_BYTES    = 12
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       uart_start,
   input  logic [NUM_BYTES-1:0][7:0]  cmd_buf,
   output logic                       tx,
   output logic                       busy,
   output logic                       done,
   output logic [1:0]                 state_dbg
);

   localparam int CNT_W  = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BYTE_W = (NUM_BYTES > 2) ? $clog2(NUM_BYTES) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t                      state, state_n;
   logic [CNT_W-1:0]            bit_cnt, bit_cnt_n;
   logic [2:0]                  bit_idx, bit_idx_n;
   logic [BYTE_W-1:0]           byte_idx, byte_idx_n;
   logic                        tx_n, done_n, load;
   logic [NUM_BYTES-1:0][7:0]   shadow;
   logic                        tick;

   assign tick      = (bit_cnt == CNT_LAST);
   assign busy      = (state != IDLE);
   assign state_dbg = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         tx       <= 1'b1;
         done     <= 1'b0;
         shadow   <= '0;
      end else begin
         state    <= state_n;
         bit_cnt  <= bit_cnt_n;
         bit_idx  <= bit_idx_n;
         byte_idx <= byte_idx_n;
         tx       <= tx_n;
         done     <= done_n;
         if (load) shadow <= cmd_buf;
      end
   end

   // tx_n is the line level for the state being entered, so tx stays registered
   always_comb begin
      state_n    = state;
      bit_cnt_n  = (state == IDLE || tick) ? '0 : bit_cnt + CNT_W'(1);
      bit_idx_n  = bit_idx;
      byte_idx_n = byte_idx;
      tx_n       = tx;
      done_n     = 1'b0;
      load       = 1'b0;
      case (state)
         IDLE: begin
            tx_n = 1'b1;
            if (uart_start) begin
               load       = 1'b1;
               byte_idx_n = '0;
               bit_idx_n  = '0;
               state_n    = START;
               tx_n       = 1'b0;
            end
         end
         START: begin
            if (tick) begin
               state_n = DATA;
               tx_n    = shadow[byte_idx][bit_idx];
            end
         end
         DATA: begin
            if (tick) begin
               bit_idx_n = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
                  state_n = STOP;
                  tx_n    = 1'b1;
               end else begin
                  tx_n = shadow[byte_idx][bit_idx_n];
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (byte_idx < BYTE_LAST) begin
                  byte_idx_n = byte_idx + BYTE_W'(1);
                  state_n    = START;
                  tx_n       = 1'b0;
               end else begin
                  state_n = IDLE;
                  done_n  = 1'b1;
                  tx_n    = 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule
